// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit; the controller decodes funct
// to op from the same constants.
package mult_div_unit_pkg;

  localparam logic [1:0] MDU_MULTU = 2'b00;
  localparam logic [1:0] MDU_MULT  = 2'b01;
  localparam logic [1:0] MDU_DIVU  = 2'b10;
  localparam logic [1:0] MDU_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    SIGN = 2'b10,
    DONE = 2'b11
  } mdu_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply, restoring divide,
// one shared WIDTH+1 adder/subtractor, fixed WIDTH+2 cycle latency.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_t         state;
  logic [CW-1:0]      counter;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;

  logic               op_signed;
  logic               op_div;
  logic               s1;
  logic               s2;
  logic [WIDTH-1:0]   abs1;
  logic [WIDTH-1:0]   abs2;

  logic [WIDTH:0]     add_a;
  logic [WIDTH:0]     add_b;
  logic [WIDTH+1:0]   add_res;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    op_signed = (op == MDU_MULT) || (op == MDU_DIV);
    op_div    = (op == MDU_DIVU) || (op == MDU_DIV);
    s1        = op_signed & In1[WIDTH-1];
    s2        = op_signed & In2[WIDTH-1];
    abs1      = s1 ? -In1 : In1;
    abs2      = s2 ? -In2 : In2;
  end

  // Shared adder: mult adds multiplicand to the upper half, div subtracts the
  // divisor from the left-shifted remainder (carry out = no borrow).
  always_comb begin
    add_a   = is_div ? acc[2*WIDTH-1:WIDTH-1] : {1'b0, acc[2*WIDTH-1:WIDTH]};
    add_b   = is_div ? ~{1'b0, opnd} : {1'b0, opnd};
    add_res = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, is_div};
    if (is_div) begin
      if (add_res[WIDTH+1])
        acc_next = {add_res[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      if (acc[0])
        acc_next = {add_res[WIDTH:0], acc[WIDTH-1:1]};
      else
        acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  // With a zero divisor the remainder ends up as |In1|; re-applying the
  // dividend sign recovers the original In1 for hi.
  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quot_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      counter  <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state    <= CALC;
            busy     <= 1'b1;
            counter  <= '0;
            is_div   <= op_div;
            neg_q    <= s1 ^ s2;
            neg_r    <= s1;
            div_zero <= (In2 == '0);
            opnd     <= op_div ? abs2 : abs1;
            acc      <= {{WIDTH{1'b0}}, (op_div ? abs1 : abs2)};
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          acc     <= acc_next;
          counter <= counter + 1'b1;
          if (counter == CW'(WIDTH-1))
            state <= SIGN;
        end
        SIGN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (!is_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (div_zero) begin
            hi <= rem_fix;
            lo <= {WIDTH{1'b1}};
          end else begin
            hi <= rem_fix;
            lo <= quot_fix;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed spec vectors, random ops
// against an arithmetic reference model, busy-start, back-to-back and reset abort.
module tb_mult_div_unit;

  localparam int W = 32;
  localparam int LAT_EDGES = W + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int total = 0;
  int bad   = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .In1(in1), .In2(in2),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic, truncating signed division.
  task automatic ref_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] rh, output logic [W-1:0] rl);
    logic [63:0] p;
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: p = {32'b0, a} * {32'b0, b};
      2'b01: p = sa * sb;
      default: p = '0;
    endcase
    if (o[1] == 1'b0) begin
      rh = p[63:32];
      rl = p[31:0];
    end else if (b == '0) begin
      rh = a;
      rl = '1;
    end else if (o == 2'b10) begin
      rh = a % b;
      rl = a / b;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      rl = q[31:0];
      rh = r[31:0];
    end
  endtask

  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    op = o; in1 = a; in2 = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns edge count to done (-1 on timeout) plus protocol observations.
  task automatic wait_done(output int edges, output bit busy_ok, output bit stable_ok);
    logic [W-1:0] h0, l0;
    h0 = hi; l0 = lo;
    busy_ok = 1'b1; stable_ok = 1'b1; edges = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done) begin
        edges = n;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (hi !== h0 || lo !== l0) stable_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = '0; in1 = '0; in2 = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, hi, lo} !== {2'b00, 64'h0}) begin
      bad++;
      $display("FAIL reset_state busy=%0b done=%0b hi=%h lo=%h required all zero", busy, done, hi, lo);
    end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic run_check(input string name, input logic [1:0] o, input logic [W-1:0] a,
                           input logic [W-1:0] b);
    logic [W-1:0] eh, el;
    int e; bit bok, sok;
    ref_model(o, a, b, eh, el);
    launch(o, a, b);
    wait_done(e, bok, sok);
    total++;
    if (e !== LAT_EDGES) begin
      bad++;
      $display("FAIL %s latency cycles=%0d required=%0d", name, e + 1, LAT_EDGES + 1);
    end
    total++;
    if (hi !== eh || lo !== el) begin
      bad++;
      $display("FAIL %s op=%0d a=%h b=%h got hi=%h lo=%h required hi=%h lo=%h",
               name, o, a, b, hi, lo, eh, el);
    end
    total++;
    if (!bok || !sok) begin
      bad++;
      $display("FAIL %s protocol busy_ok=%0b stable_ok=%0b required 1 1", name, bok, sok);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] eh, el;
    run_check("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    total++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      bad++;
      $display("FAIL multu_max_const got hi=%h lo=%h required hi=fffffffe lo=00000001", hi, lo);
    end
    run_check("mult_neg", 2'b01, -32'sd3, 32'd7);
    run_check("mult_min", 2'b01, 32'h80000000, 32'h80000000);
    run_check("div_neg", 2'b11, -32'sd7, 32'd2);
    total++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      bad++;
      $display("FAIL div_neg_const got hi=%h lo=%h required hi=ffffffff lo=fffffffd", hi, lo);
    end
    run_check("divu_100_7", 2'b10, 32'd100, 32'd7);
    run_check("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF);
    total++;
    if (hi !== 32'h0 || lo !== 32'h80000000) begin
      bad++;
      $display("FAIL div_ovf_const got hi=%h lo=%h required hi=00000000 lo=80000000", hi, lo);
    end
    run_check("div_zero", 2'b11, 32'h12345678, 32'h0);
    run_check("divu_zero", 2'b10, 32'h12345678, 32'h0);
    run_check("div_zero_neg", 2'b11, 32'hF0000001, 32'h0);
    ref_model(2'b10, 32'h12345678, 32'h0, eh, el);
    total++;
    if (eh !== 32'h12345678 || el !== 32'hFFFFFFFF) begin
      bad++;
      $display("FAIL ref_div_zero model hi=%h lo=%h required hi=12345678 lo=ffffffff", eh, el);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] pool [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};
    logic [W-1:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(0, 31);
      run_check("random", 2'($urandom_range(0, 3)), a, b);
    end
  endtask

  task automatic test_start_while_busy;
    logic [W-1:0] eh, el;
    int dones = 0, first = -1;
    ref_model(2'b01, 32'hDEAD0001, 32'h00C0FFEE, eh, el);
    launch(2'b01, 32'hDEAD0001, 32'h00C0FFEE);
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        if (first < 0) first = n;
      end
      if (n == 4 || n == 19) begin
        start = 1'b1; op = 2'b10; in1 = 32'd55; in2 = 32'd3;
      end else begin
        start = 1'b0;
      end
    end
    total++;
    if (dones !== 1 || first !== LAT_EDGES) begin
      bad++;
      $display("FAIL busy_start dones=%0d at_cycle=%0d required dones=1 at_cycle=%0d",
               dones, first + 1, LAT_EDGES + 1);
    end
    total++;
    if (hi !== eh || lo !== el) begin
      bad++;
      $display("FAIL busy_start_result got hi=%h lo=%h required hi=%h lo=%h", hi, lo, eh, el);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] h1, l1, eh, el;
    int e; bit bok, sok;
    ref_model(2'b00, 32'h00010003, 32'h00020005, h1, l1);
    ref_model(2'b11, 32'hFFFFFF00, 32'd9, eh, el);
    launch(2'b00, 32'h00010003, 32'h00020005);
    wait_done(e, bok, sok);
    start = 1'b1; op = 2'b11; in1 = 32'hFFFFFF00; in2 = 32'd9;
    @(posedge clk); #1 start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || hi !== h1 || lo !== l1) begin
      bad++;
      $display("FAIL b2b_accept busy=%0b done=%0b hi=%h lo=%h required busy=1 done=0 hi=%h lo=%h",
               busy, done, hi, lo, h1, l1);
    end
    wait_done(e, bok, sok);
    total++;
    if (e !== LAT_EDGES || !bok || !sok) begin
      bad++;
      $display("FAIL b2b_second cycles=%0d busy_ok=%0b stable_ok=%0b required cycles=%0d 1 1",
               e + 1, bok, sok, LAT_EDGES + 1);
    end
    total++;
    if (hi !== eh || lo !== el) begin
      bad++;
      $display("FAIL b2b_result got hi=%h lo=%h required hi=%h lo=%h", hi, lo, eh, el);
    end
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    launch(2'b00, 32'h11111111, 32'h22222222);
    repeat (14) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({busy, done, hi, lo} !== {2'b00, 64'h0}) begin
      bad++;
      $display("FAIL reset_mid busy=%0b done=%0b hi=%h lo=%h required all zero", busy, done, hi, lo);
    end
    @(negedge clk) reset = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL reset_mid_no_done dones=%0d required 0", dones);
    end
    run_check("after_reset", 2'b11, 32'hFFFFF000, 32'h00000013);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
